axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  2:1 AXI4-Lite read-channel arbiter between the core's instruction fetch (m0) and load/store (m1)
//  read masters and the single memory slave (axi_slave). Serialises AR/R traffic: one outstanding
//  read at a time. The write channels (AW/W/B) bypass this block, LSU -> slave directly.
// PARAMETERS
//  ADDR_W   32   address width, AR channel
//  DATA_W   32   data width, R channel
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       reset, asynchronous, active-low
//  m{0,1}_ar_valid_i in  1       master read-address valid
//  m{0,1}_ar_addr_i in   ADDR_W  master read address
//  m{0,1}_ar_ready_o out 1       address accepted by arbiter
//  m{0,1}_r_valid_o out  1       read data valid to master
//  m{0,1}_r_data_o  out  DATA_W  read data to master
//  m{0,1}_r_resp_o  out  2       read response to master
//  m{0,1}_r_ready_i in   1       master ready for read data
//  s_ar_valid_o     out  1       slave read-address valid
//  s_ar_addr_o      out  ADDR_W  slave read address (registered)
//  s_ar_ready_i     in   1       slave accepted address
//  s_r_valid_i      in   1       slave read data valid
//  s_r_data_i       in   DATA_W  slave read data
//  s_r_resp_i       in   2       slave read response
//  s_r_ready_o      out  1       ready for slave read data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, gnt=0, last=1 (m1), s_ar_addr_o=0; every valid/ready output 0.
//  FSM IDLE -> SADDR -> SDATA -> IDLE; gnt (1 bit) names the owning master, held SADDR..SDATA.
//  IDLE: win = arbitration of {m0_ar_valid_i, m1_ar_valid_i}; mW_ar_ready_o=1 combinationally for
//    winner only, loser 0. On handshake: latch addr into s_ar_addr_o, gnt<=W, -> SADDR. No request: stay.
//  SADDR: s_ar_valid_o=1 (earliest cycle N+1 after accept at N); hold addr stable; all m*_ar_ready_o=0.
//    On s_ar_ready_i -> SDATA; s_ar_valid_o drops next cycle.
//  SDATA: m[gnt]_r_valid_o=s_r_valid_i, m[gnt]_r_data_o=s_r_data_i, m[gnt]_r_resp_o=s_r_resp_i;
//    s_r_ready_o=m[gnt]_r_ready_i (combinational pass-through, zero added latency on R).
//    Other master: r_valid_o=0, r_data_o=0, r_resp_o=0. On s_r_valid_i&s_r_ready_o: last<=gnt, -> IDLE.
//  Min read latency seen by master: accept N, s_ar_valid N+1, data same cycle as slave rvalid.
//  New AR never accepted in SADDR/SDATA (back-to-back reads cost >=1 IDLE cycle).
//  Response resp passed unmodified (SLVERR/DECERR forwarded, no retry).
//  Master deasserting ar_valid before ready is an AXI violation: not handled, not checked.
//  Master holding r_ready=0: arbiter stalls in SDATA indefinitely (backpressure to slave).
//  Reset asserted mid-transaction: immediate IDLE, in-flight address/response discarded, no output
//    glitch beyond the asynchronous clear; slave is reset by the same rst.
// CONFIGURATION
//  AXI_ARB_RR_EN defined: round-robin. Both valid in IDLE -> grant the master != last; one valid ->
//    grant it. After reset last=m1, so first tie goes to m0.
//  AXI_ARB_RR_EN undefined: fixed priority, m1 (LSU) always wins ties; last register still present
//    but unused for arbitration. m0 can starve under continuous m1 requests (accepted).
// TESTING
//  Single m0 read 0x8000_0000, slave arready same cycle, rdata 0xDEAD_BEEF -> m0 gets
//    r_valid with 0xDEAD_BEEF resp=0; m1_r_valid_o stays 0; FSM back in IDLE.
//  m0,m1 valid same cycle (addr 0x100/0x200), RR_EN: m0 first, then m1; fixed: m1 first, then m0;
//    s_ar_addr_o sequence matches, each data routed to the correct master.
//  Slave holds arready=0 for 5 cycles -> s_ar_valid_o and s_ar_addr_o stable all 5 cycles,
//    m*_ar_ready_o=0 throughout.
//  Master r_ready=0 for 3 cycles while slave rvalid=1 -> s_r_ready_o=0, no state change; completes
//    on cycle r_ready rises.
//  rst pulled low in SDATA -> all outputs 0 asynchronously; after release next m1 read
//    completes normally; slave resp=2'b10 forwarded unchanged.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4-Lite read-channel arbiter (fetch m0 / LSU m1 -> one slave), one outstanding read at a time.
// Define AXI_ARB_RR_EN for round-robin ties; otherwise fixed priority with m1 winning ties.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ar_valid_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_ar_ready_o,
  output logic              m0_r_valid_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic [1:0]        m0_r_resp_o,
  input  logic              m0_r_ready_i,
  input  logic              m1_ar_valid_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_ar_ready_o,
  output logic              m1_r_valid_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  output logic [1:0]        m1_r_resp_o,
  input  logic              m1_r_ready_i,
  output logic              s_ar_valid_o,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_ar_ready_i,
  input  logic              s_r_valid_i,
  input  logic [DATA_W-1:0] s_r_data_i,
  input  logic [1:0]        s_r_resp_i,
  output logic              s_r_ready_o
);

  typedef enum logic [1:0] {IDLE, SADDR, SDATA} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic any_req;
  logic win;
  logic ar_hs;
  logic gnt_r_ready;
  logic r_hs;

  always_comb begin
    any_req = m0_ar_valid_i | m1_ar_valid_i;
`ifdef AXI_ARB_RR_EN
    if (m0_ar_valid_i && m1_ar_valid_i) begin
      win = ~last_q;
    end else begin
      win = m1_ar_valid_i;
    end
`else
    win = m1_ar_valid_i;
`endif
  end

  // ar_ready is gated by rst so no handshake can be signalled while reset is held
  assign ar_hs       = (state_q == IDLE) && rst && any_req;
  assign gnt_r_ready = gnt_q ? m1_r_ready_i : m0_r_ready_i;
  assign r_hs        = (state_q == SDATA) && s_r_valid_i && gnt_r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d  = win ? m1_ar_addr_i : m0_ar_addr_i;
          gnt_d   = win;
          state_d = SADDR;
        end
      end
      SADDR: begin
        if (s_ar_ready_i) begin
          state_d = SDATA;
        end
      end
      SDATA: begin
        if (r_hs) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // R channel is a pure pass-through to the granted master; the other master sees zeros
  always_comb begin
    m0_ar_ready_o = 1'b0;
    m1_ar_ready_o = 1'b0;
    s_ar_valid_o  = 1'b0;
    m0_r_valid_o  = 1'b0;
    m0_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m1_r_valid_o  = 1'b0;
    m1_r_data_o   = '0;
    m1_r_resp_o   = 2'b00;
    s_r_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        m0_ar_ready_o = ar_hs & ~win;
        m1_ar_ready_o = ar_hs & win;
      end
      SADDR: begin
        s_ar_valid_o = 1'b1;
      end
      SDATA: begin
        s_r_ready_o = gnt_r_ready;
        if (gnt_q) begin
          m1_r_valid_o = s_r_valid_i;
          m1_r_data_o  = s_r_data_i;
          m1_r_resp_o  = s_r_resp_i;
        end else begin
          m0_r_valid_o = s_r_valid_i;
          m0_r_data_o  = s_r_data_i;
          m0_r_resp_o  = s_r_resp_i;
        end
      end
      default: begin
        s_ar_valid_o = 1'b0;
      end
    endcase
  end

  assign s_ar_addr_o = addr_q;

endmodule
